id_stage_reg: RTL and testbench
===============================

# id_stage_reg

Instruction-decode pipeline register between fetch and execute. It captures a 32-bit MIPS instruction and PC from fetch over a valid/ready handshake and splits the instruction into its fields. The 16-bit immediate feeds the downstream sign extender and the register numbers feed the register file. The stage also inserts load-use bubbles and honours branch flushes.

## Interface
- BUBBLE_CYCLES, 1: stall cycles inserted per detected load-use hazard (1–3).
- CNT_W, 16: width of the saturating bubble counter.

Clock and reset are one clock, with reset asynchronous and active-low.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage can accept an instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  PC of the instruction
- flush  in  1  synchronous discard of the held instruction (branch/jump taken)
- ex_load_valid  in  1  the instruction currently in EX is a load
- ex_load_rt  in  5  destination register of that load
- id_valid  out  1  decoded instruction valid to EX
- id_ready  in  1  EX accepts this cycle
- id_pc  out  32  held PC
- id_opcode  out  6  instr[31:26]
- id_rs  out  5  instr[25:21]
- id_rt  out  5  instr[20:16]
- id_rd  out  5  instr[15:11]
- id_shamt  out  5  instr[10:6]
- id_funct  out  6  instr[5:0]
- id_imm16  out  16  instr[15:0], to sign extender
- id_target  out  26  instr[25:0]
- id_rtype  out  1  opcode == 0
- id_jtype  out  1  opcode == 2 or 3
- bubble_cnt  out  CNT_W  total bubbles inserted, saturating

## Operation
- States:
  - IDLE: empty.
  - HOLD: an instruction is held.
  - BUBBLE: a hazard stall is in progress, with the instruction still held.
- The field outputs are combinational slices of the held instruction register. They remain stable while the stage is in HOLD or BUBBLE.
- The held instruction reads rt when it is R-type, or when its opcode is 0x04 (beq), 0x05 (bne) or 0x2B (sw).
- hazard = HOLD & ~hz_done & ex_load_valid & ex_load_rt≠0 & (ex_load_rt==id_rs | (ex_load_rt==id_rt & reads_rt)).
- id_valid = HOLD & ~hazard.
- if_ready = IDLE | (HOLD & ~hazard & id_ready). A pass-through capture is permitted in the same cycle as an EX accept.
- Transitions, with flush taking priority over all others:
  - Any state with flush → IDLE. A same-cycle if_valid is dropped. The BUBBLE counter clears. hz_done clears.
  - IDLE with if_valid → HOLD. The stage captures instr and pc and clears hz_done.
  - HOLD with hazard → BUBBLE. The stage loads bub_ctr = BUBBLE_CYCLES−1. bubble_cnt increments by 1 and saturates at all-ones.
  - HOLD with id_ready & if_valid → HOLD. The stage captures the new instruction and clears hz_done.
  - HOLD with id_ready & ~if_valid → IDLE.
  - BUBBLE with bub_ctr==0 → HOLD and sets hz_done. Only one hazard stall is taken per captured instruction.
  - BUBBLE with bub_ctr≠0 → decrements bub_ctr.
- In BUBBLE, id_valid and if_ready are both 0.

## Timing
- Latency: an instruction accepted at edge N is presented with id_valid=1 after edge N. This is one cycle of latency when no hazard occurs.
- With a hazard, id_valid stays 0 for exactly BUBBLE_CYCLES+1 cycles: the detection cycle plus the BUBBLE cycles.
- Throughput: one instruction per cycle when id_ready=1 and no hazards occur.
- Reset values:
  - State = IDLE.
  - Held instr and pc = 0, so all field outputs and id_pc read 0.
  - id_valid = 0 and if_ready = 1.
  - bub_ctr = 0, hz_done = 0, bubble_cnt = 0.
- Reset asserted mid-operation immediately forces these values, with no drain.
- If id_ready=0 in HOLD, the held instruction and all outputs remain unchanged and if_ready=0.
- If flush and id_ready coincide, EX's acceptance stands (the transfer occurred) and the stage still empties.
- if_valid while in BUBBLE is ignored. Fetch must hold it until if_ready is 1.

## Test plan
- Reset, then send 0x8C22_0004 (lw $2,4($1)) at pc 0x0040_0000 with id_ready=1. Required response, one cycle later:
  - id_valid=1
  - opcode=0x23, rs=1, rt=2
  - imm16=0x0004, pc=0x0040_0000
- Stream 0x0022_1820 and 0x0043_2022 back-to-back with id_ready=1. Required response: id_valid=1 on consecutive cycles, with rd=3 then rd=4, funct=0x20 then 0x22.
- Hold 0x0022_1820 while ex_load_valid=1 and ex_load_rt=2, with BUBBLE_CYCLES=1. Required response:
  - id_valid=0 for 2 cycles, then 1.
  - bubble_cnt=1.
  - if_ready=0 throughout the stall.
- Repeat the previous case with ex_load_rt=0 and with ex_load_rt=5. Required response: no bubble, and bubble_cnt is unchanged.
- Hold an instruction with id_ready=0, then pulse flush together with if_valid. Required response: id_valid=0 next cycle, the new instruction is not captured, and if_ready=1.
- Drop rst_n asynchronously while in BUBBLE. Required response: id_valid=0, all fields 0, bubble_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/id_stage_reg_if.sv
// Fetch/decode/execute handshake bundle for the ID pipeline register.
// The stage connects through the slave modport; the fetch/EX side uses master.
interface id_stage_reg_if #(
    parameter int CNT_W = 16
);
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              flush;
    logic              ex_load_valid;
    logic [4:0]        ex_load_rt;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_pc;
    logic [5:0]        id_opcode;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [4:0]        id_shamt;
    logic [5:0]        id_funct;
    logic [15:0]       id_imm16;
    logic [25:0]       id_target;
    logic              id_rtype;
    logic              id_jtype;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output if_valid, if_instr, if_pc, flush, ex_load_valid, ex_load_rt, id_ready,
        input  if_ready, id_valid, id_pc, id_opcode, id_rs, id_rt, id_rd, id_shamt,
               id_funct, id_imm16, id_target, id_rtype, id_jtype, bubble_cnt
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, ex_load_valid, ex_load_rt, id_ready,
        output if_ready, id_valid, id_pc, id_opcode, id_rs, id_rt, id_rd, id_shamt,
               id_funct, id_imm16, id_target, id_rtype, id_jtype, bubble_cnt
    );
endinterface

// File: rtl/id_stage_reg.sv
// MIPS ID pipeline register: valid/ready capture from fetch, field split,
// one load-use bubble burst per held instruction, and branch flush.
module id_stage_reg #(
    parameter int BUBBLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_stage_reg_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, BUBBLE} state_t;

    localparam logic [1:0] BUB_INIT = 2'(BUBBLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [1:0]       ctr_q, ctr_d;
    logic             hz_done_q, hz_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0] opcode;
    logic [4:0] rs, rt;
    logic       rtype, reads_rt, hazard, in_hold;

    assign opcode   = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rtype    = (opcode == 6'h00);
    // Stores and the two compare branches read rt even though they are not R-type.
    assign reads_rt = rtype || opcode == 6'h04 || opcode == 6'h05 || opcode == 6'h2B;
    assign in_hold  = (state_q == HOLD);

    assign hazard = in_hold && !hz_done_q && bus.ex_load_valid && (bus.ex_load_rt != 5'd0) &&
                    ((bus.ex_load_rt == rs) || ((bus.ex_load_rt == rt) && reads_rt));

    assign bus.id_valid   = in_hold && !hazard;
    assign bus.if_ready   = (state_q == IDLE) || (in_hold && !hazard && bus.id_ready);
    assign bus.id_pc      = pc_q;
    assign bus.id_opcode  = opcode;
    assign bus.id_rs      = rs;
    assign bus.id_rt      = rt;
    assign bus.id_rd      = instr_q[15:11];
    assign bus.id_shamt   = instr_q[10:6];
    assign bus.id_funct   = instr_q[5:0];
    assign bus.id_imm16   = instr_q[15:0];
    assign bus.id_target  = instr_q[25:0];
    assign bus.id_rtype   = rtype;
    assign bus.id_jtype   = (opcode == 6'h02) || (opcode == 6'h03);
    assign bus.bubble_cnt = cnt_q;

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path infers a latch.
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        ctr_d     = ctr_q;
        hz_done_d = hz_done_q;
        cnt_d     = cnt_q;
        if (bus.flush) begin
            state_d   = IDLE;
            ctr_d     = 2'd0;
            hz_done_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.if_valid) begin
                    state_d   = HOLD;
                    instr_d   = bus.if_instr;
                    pc_d      = bus.if_pc;
                    hz_done_d = 1'b0;
                end
                HOLD: if (hazard) begin
                    state_d = BUBBLE;
                    ctr_d   = BUB_INIT;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end else if (bus.id_ready) begin
                    if (bus.if_valid) begin
                        instr_d   = bus.if_instr;
                        pc_d      = bus.if_pc;
                        hz_done_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUBBLE: if (ctr_q == 2'd0) begin
                    state_d   = HOLD;
                    hz_done_d = 1'b1;
                end else begin
                    ctr_d = ctr_q - 2'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the instruction/PC register is reset too, because the field outputs must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            pc_q      <= '0;
            ctr_q     <= 2'd0;
            hz_done_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            ctr_q     <= ctr_d;
            hz_done_q <= hz_done_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_id_stage_reg.sv
// Self-checking bench for id_stage_reg: directed scenarios plus randomized
// traffic compared cycle by cycle against an abstract pipeline-slot model.
module tb_id_stage_reg;
    localparam int BUB   = 1;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_reg_if #(.CNT_W(CNT_W)) bus ();

    id_stage_reg #(.BUBBLE_CYCLES(BUB), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: one slot that is either empty or holds an instruction,
    // plus how many stall cycles remain and whether this one already stalled.
    bit          have;
    logic [31:0] m_instr, m_pc;
    int          stall_left;
    bit          stalled_once;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit uses_rt(input logic [31:0] ins);
        return ins[31:26] == 6'h00 || ins[31:26] == 6'h04 ||
               ins[31:26] == 6'h05 || ins[31:26] == 6'h2B;
    endfunction

    function automatic bit model_hazard();
        return have && stall_left == 0 && !stalled_once && bus.ex_load_valid &&
               bus.ex_load_rt != 5'd0 &&
               (bus.ex_load_rt == m_instr[25:21] ||
                (bus.ex_load_rt == m_instr[20:16] && uses_rt(m_instr)));
    endfunction

    function automatic bit model_valid();
        return have && stall_left == 0 && !model_hazard();
    endfunction

    task automatic model_reset();
        have = 0; m_instr = '0; m_pc = '0;
        stall_left = 0; stalled_once = 0; m_cnt = 0;
    endtask

    task automatic compare_model();
        logic [5:0] op;
        op = m_instr[31:26];
        check("id_valid", 32'(bus.id_valid), 32'(model_valid()));
        check("if_ready", 32'(bus.if_ready), 32'(!have || (model_valid() && bus.id_ready)));
        check("id_pc", bus.id_pc, m_pc);
        check("fields", {bus.id_opcode, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_funct},
              m_instr);
        check("imm16", 32'(bus.id_imm16), 32'(m_instr[15:0]));
        check("target", 32'(bus.id_target), 32'(m_instr[25:0]));
        check("rtype", 32'(bus.id_rtype), 32'(op == 6'd0));
        check("jtype", 32'(bus.id_jtype), 32'(op == 6'd2 || op == 6'd3));
        check("bubble_cnt", 32'(bus.bubble_cnt), 32'(m_cnt));
    endtask

    // Advance the model using the inputs that were present at the edge.
    task automatic model_edge();
        bit hz, v;
        hz = model_hazard();
        v  = model_valid();
        if (bus.flush) begin
            have = 0; stall_left = 0; stalled_once = 0;
        end else if (!have) begin
            if (bus.if_valid) begin
                have = 1; m_instr = bus.if_instr; m_pc = bus.if_pc; stalled_once = 0;
            end
        end else if (stall_left > 0) begin
            stall_left--;
        end else if (hz) begin
            stall_left = BUB; stalled_once = 1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (v && bus.id_ready) begin
            if (bus.if_valid) begin
                m_instr = bus.if_instr; m_pc = bus.if_pc; stalled_once = 0;
            end else begin
                have = 0;
            end
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit rdy,
                         input bit fl, input bit lv, input logic [4:0] lrt);
        bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc; bus.id_ready = rdy;
        bus.flush = fl; bus.ex_load_valid = lv; bus.ex_load_rt = lrt;
    endtask

    task automatic half();
        @(negedge clk);
        compare_model();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [31:0] ins;
        logic [5:0]  ops [8];
        logic [4:0]  lrt;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h08};

        drive(0, '0, '0, 1, 0, 0, 5'd0);
        model_reset();
        #12;
        check("reset_valid", 32'(bus.id_valid), 32'd0);
        check("reset_ready", 32'(bus.if_ready), 32'd1);
        check("reset_pc", bus.id_pc, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // lw $2,4($1): presented one cycle after acceptance
        drive(1, 32'h8C22_0004, 32'h0040_0000, 1, 0, 0, 5'd0);
        half(); edge_step();
        drive(0, '0, '0, 1, 0, 0, 5'd0);
        half();
        check("lw_valid", 32'(bus.id_valid), 32'd1);
        check("lw_opcode", 32'(bus.id_opcode), 32'h23);
        check("lw_rs", 32'(bus.id_rs), 32'd1);
        check("lw_rt", 32'(bus.id_rt), 32'd2);
        check("lw_imm", 32'(bus.id_imm16), 32'h0004);
        check("lw_pc", bus.id_pc, 32'h0040_0000);
        edge_step();

        // back-to-back add/sub
        drive(1, 32'h0022_1820, 32'h0040_0010, 1, 0, 0, 5'd0);
        half(); edge_step();
        drive(1, 32'h0043_2022, 32'h0040_0014, 1, 0, 0, 5'd0);
        half();
        check("s1_valid", 32'(bus.id_valid), 32'd1);
        check("s1_rd", 32'(bus.id_rd), 32'd3);
        check("s1_funct", 32'(bus.id_funct), 32'h20);
        edge_step();
        drive(0, '0, '0, 1, 0, 0, 5'd0);
        half();
        check("s2_valid", 32'(bus.id_valid), 32'd1);
        check("s2_rd", 32'(bus.id_rd), 32'd4);
        check("s2_funct", 32'(bus.id_funct), 32'h22);
        edge_step();

        // load-use on rt=2: two invalid cycles, then valid
        drive(1, 32'h0022_1820, 32'h0040_0020, 1, 0, 0, 5'd0);
        half(); edge_step();
        drive(0, '0, '0, 1, 0, 1, 5'd2);
        for (int i = 0; i < 2; i++) begin
            half();
            check("hz_valid", 32'(bus.id_valid), 32'd0);
            check("hz_ready", 32'(bus.if_ready), 32'd0);
            edge_step();
        end
        half();
        check("hz_after_valid", 32'(bus.id_valid), 32'd1);
        check("hz_cnt", 32'(bus.bubble_cnt), 32'd1);
        edge_step();

        // ex_load_rt of 0 or an unrelated register must not stall
        for (int k = 0; k < 2; k++) begin
            lrt = (k == 0) ? 5'd0 : 5'd5;
            drive(1, 32'h0022_1820, 32'h0040_0030, 1, 0, 0, 5'd0);
            half(); edge_step();
            drive(0, '0, '0, 1, 0, 1, lrt);
            half();
            check("nohz_valid", 32'(bus.id_valid), 32'd1);
            check("nohz_cnt", 32'(bus.bubble_cnt), 32'd1);
            edge_step();
        end

        // held with id_ready=0, then flush with a competing if_valid
        drive(1, 32'h2001_0007, 32'h0040_0040, 0, 0, 0, 5'd0);
        half(); edge_step();
        drive(0, '0, '0, 0, 0, 0, 5'd0);
        half();
        check("stall_ready", 32'(bus.if_ready), 32'd0);
        edge_step();
        drive(1, 32'h1234_5678, 32'h0040_0099, 0, 1, 0, 5'd0);
        half(); edge_step();
        drive(0, '0, '0, 0, 0, 0, 5'd0);
        half();
        check("flush_valid", 32'(bus.id_valid), 32'd0);
        check("flush_ready", 32'(bus.if_ready), 32'd1);
        check("flush_pc", bus.id_pc, 32'h0040_0040);
        edge_step();

        // async reset while in BUBBLE
        drive(1, 32'hAC22_0008, 32'h0040_0050, 1, 0, 0, 5'd0);
        half(); edge_step();
        drive(0, '0, '0, 1, 0, 1, 5'd1);
        half(); edge_step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.id_valid), 32'd0);
        check("arst_fields", {bus.id_opcode, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_funct},
              32'd0);
        check("arst_pc", bus.id_pc, 32'd0);
        check("arst_cnt", 32'(bus.bubble_cnt), 32'd0);
        model_reset();
        drive(0, '0, '0, 1, 0, 0, 5'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: lrt = 5'd0;
                1: lrt = m_instr[25:21];
                2: lrt = m_instr[20:16];
                default: lrt = 5'($urandom);
            endcase
            drive($urandom_range(0, 9) < 6, ins, $urandom, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 5, lrt);
            half(); edge_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
